// File: rtl/tdc_thermo_decoder.sv
// tdc_thermo_decoder: converts a sampled thermometer code into a binary fine timestamp,
// pairs it with a free-running coarse count and delivers it through a 3-stage elastic
// pipeline (S1 capture, S2 correction, S3 encode/output) with a valid/ready handshake.
// Build option: define TDC_BUBBLE_CORR_EN to enable majority-of-3 bubble correction in S2;
// without it S2 registers the raw code.
module tdc_thermo_decoder #(
  parameter int unsigned NTAPS    = 32,
  parameter int unsigned FINE_W   = 5,
  parameter int unsigned COARSE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit_valid,
  input  logic [NTAPS-1:0]    thermo_in,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [FINE_W-1:0]   ts_fine,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic                ts_err,
  output logic                overflow,
  input  logic                overflow_clr
);

  logic [COARSE_W-1:0] coarse_q, coarse_d;

  logic                s1_valid_q, s1_valid_d;
  logic [NTAPS-1:0]    s1_code_q, s1_code_d;
  logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;

  logic                s2_valid_q, s2_valid_d;
  logic [NTAPS-1:0]    s2_code_q, s2_code_d;
  logic [COARSE_W-1:0] s2_coarse_q, s2_coarse_d;

  logic                s3_valid_q, s3_valid_d;
  logic [FINE_W-1:0]   s3_fine_q, s3_fine_d;
  logic [COARSE_W-1:0] s3_coarse_q, s3_coarse_d;
  logic                s3_err_q, s3_err_d;

  logic                overflow_q, overflow_d;

  logic                s3_pop, s3_free, adv3, s2_free, adv2, s1_free, accept, drop;
  logic [NTAPS-1:0]    corr_code;
  logic [FINE_W:0]     ones;
  logic [FINE_W-1:0]   enc_fine;
  logic                enc_err;

  // Elastic handshake: each stage advances when the next is empty or emptying this cycle.
  // ts_ready only reaches accept/advance logic, never ts_valid (a flop output).
  always_comb begin
    s3_pop  = s3_valid_q & ts_ready;
    s3_free = ~s3_valid_q | ts_ready;
    adv3    = s2_valid_q & s3_free;
    s2_free = ~s2_valid_q | adv3;
    adv2    = s1_valid_q & s2_free;
    s1_free = ~s1_valid_q | adv2;
    accept  = hit_valid & s1_free;
    drop    = hit_valid & ~s1_free;
  end

`ifdef TDC_BUBBLE_CORR_EN
  logic [NTAPS+1:0] ext_code;

  // Majority-of-3 per tap; the code is padded with a 1 below tap 0 and a 0 above the top tap.
  always_comb begin
    ext_code  = {1'b0, s1_code_q, 1'b1};
    corr_code = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      corr_code[i] = (ext_code[i] & ext_code[i+1]) | (ext_code[i] & ext_code[i+2]) |
                     (ext_code[i+1] & ext_code[i+2]);
    end
  end
`else
  // Correction disabled: the raw code passes through S2 unchanged.
  always_comb begin
    corr_code = s1_code_q;
  end
`endif

  // Encode: popcount, fine = ones-1 (0 when empty), error on empty or any 0-below-1 bubble.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      ones = ones + {{FINE_W{1'b0}}, s2_code_q[i]};
    end
    // With all taps set ones[FINE_W-1:0] is 0, so the low-bit decrement wraps to NTAPS-1.
    enc_fine = (ones == '0) ? '0 : (ones[FINE_W-1:0] - {{(FINE_W-1){1'b0}}, 1'b1});
    enc_err  = (ones == '0) | (|(~s2_code_q[NTAPS-2:0] & s2_code_q[NTAPS-1:1]));
  end

  // Next-state for the coarse counter, the three stages and the sticky overflow flag.
  always_comb begin
    coarse_d    = coarse_q + {{(COARSE_W-1){1'b0}}, 1'b1};

    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    s1_coarse_d = s1_coarse_q;
    if (adv2) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_code_d   = thermo_in;
      s1_coarse_d = coarse_q;
    end

    s2_valid_d  = s2_valid_q;
    s2_code_d   = s2_code_q;
    s2_coarse_d = s2_coarse_q;
    if (adv3) s2_valid_d = 1'b0;
    if (adv2) begin
      s2_valid_d  = 1'b1;
      s2_code_d   = corr_code;
      s2_coarse_d = s1_coarse_q;
    end

    // Output data only changes on a load, so it stays stable while stalled.
    s3_valid_d  = s3_valid_q;
    s3_fine_d   = s3_fine_q;
    s3_coarse_d = s3_coarse_q;
    s3_err_d    = s3_err_q;
    if (s3_pop) s3_valid_d = 1'b0;
    if (adv3) begin
      s3_valid_d  = 1'b1;
      s3_fine_d   = enc_fine;
      s3_coarse_d = s2_coarse_q;
      s3_err_d    = enc_err;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_coarse_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_code_q   <= '0;
      s2_coarse_q <= '0;
      s3_valid_q  <= 1'b0;
      s3_fine_q   <= '0;
      s3_coarse_q <= '0;
      s3_err_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      coarse_q    <= coarse_d;
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_coarse_q <= s1_coarse_d;
      s2_valid_q  <= s2_valid_d;
      s2_code_q   <= s2_code_d;
      s2_coarse_q <= s2_coarse_d;
      s3_valid_q  <= s3_valid_d;
      s3_fine_q   <= s3_fine_d;
      s3_coarse_q <= s3_coarse_d;
      s3_err_q    <= s3_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ts_valid  = s3_valid_q;
  assign ts_fine   = s3_fine_q;
  assign ts_coarse = s3_coarse_q;
  assign ts_err    = s3_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Directed self-checking bench for tdc_thermo_decoder (NTAPS=32, FINE_W=5, COARSE_W=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tdc_thermo_decoder;

  logic        clk;
  logic        rst;
  logic        hit_valid;
  logic [31:0] thermo_in;
  logic        ts_valid;
  logic        ts_ready;
  logic [4:0]  ts_fine;
  logic [15:0] ts_coarse;
  logic        ts_err;
  logic        overflow;
  logic        overflow_clr;

  int checks = 0;
  int errors = 0;

  // Expected coarse count: zero in reset, +1 per rising edge otherwise.
  logic [15:0] cnt_m;

  tdc_thermo_decoder #(
    .NTAPS   (32),
    .FINE_W  (5),
    .COARSE_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hit_valid   (hit_valid),
    .thermo_in   (thermo_in),
    .ts_valid    (ts_valid),
    .ts_ready    (ts_ready),
    .ts_fine     (ts_fine),
    .ts_coarse   (ts_coarse),
    .ts_err      (ts_err),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt_m <= 16'h0;
    else     cnt_m <= cnt_m + 16'h1;
  end

  // Present one hit with ts_ready high and wait (bounded) for the first ts_valid.
  task automatic hit_and_wait(input logic [31:0] code, output logic got,
                              output logic [4:0] f, output logic [15:0] c,
                              output logic e, output int lat);
    got = 1'b0; f = '0; c = '0; e = 1'b0; lat = 0;
    ts_ready  = 1'b1;
    hit_valid = 1'b1;
    thermo_in = code;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) hit_valid = 1'b0;
      if (ts_valid) begin
        got = 1'b1; f = ts_fine; c = ts_coarse; e = ts_err; lat = i;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget);
    int n = 0;
    while (cnt_m != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cnt_m != target) begin
      errors++;
      $display("FAIL wait_cnt: counter model %0h never reached %0h", cnt_m, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hit_valid = 1'b0; thermo_in = '0; ts_ready = 1'b0; overflow_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ts_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (ts_fine !== 5'd0) begin errors++; $display("FAIL reset_fine: got %0d want 0", ts_fine); end
    checks++; if (ts_coarse !== 16'd0) begin errors++; $display("FAIL reset_coarse: got %0h want 0", ts_coarse); end
    checks++; if (ts_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ts_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_hit();
    logic got, e; logic [4:0] f; logic [15:0] c; int lat;
    wait_cnt(16'd10, 100);
    hit_and_wait(32'h0000_00FF, got, f, c, e, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_got: got %b want 1 (timeout)", got); end
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
    checks++; if (f !== 5'd7) begin errors++; $display("FAIL single_fine: got %0d want 7", f); end
    checks++; if (c !== 16'd10) begin errors++; $display("FAIL single_coarse: got %0d want 10", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", e); end
    @(negedge clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", ts_valid); end
  endtask

  task automatic test_bubble();
    logic got, e; logic [4:0] f; logic [15:0] c; int lat;
    logic [4:0] exp_f; logic exp_e;
`ifdef TDC_BUBBLE_CORR_EN
    exp_f = 5'd7; exp_e = 1'b0;
`else
    exp_f = 5'd6; exp_e = 1'b1;
`endif
    hit_and_wait(32'h0000_00F7, got, f, c, e, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bubble_got: got %b want 1 (timeout)", got); end
    checks++; if (f !== exp_f) begin errors++; $display("FAIL bubble_fine: got %0d want %0d", f, exp_f); end
    checks++; if (e !== exp_e) begin errors++; $display("FAIL bubble_err: got %b want %b", e, exp_e); end
  endtask

  task automatic test_boundaries();
    logic got, e; logic [4:0] f; logic [15:0] c; int lat;
    logic [31:0] codes [3];
    logic [4:0]  exp_f [3];
    logic        exp_e [3];
    codes[0] = 32'hFFFF_FFFF; exp_f[0] = 5'd31; exp_e[0] = 1'b0;
    codes[1] = 32'h0000_0000; exp_f[1] = 5'd0;  exp_e[1] = 1'b1;
    codes[2] = 32'h0000_0001; exp_f[2] = 5'd0;  exp_e[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hit_and_wait(codes[k], got, f, c, e, lat);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL bound%0d_got: got %b want 1", k, got); end
      checks++; if (f !== exp_f[k]) begin errors++; $display("FAIL bound%0d_fine: got %0d want %0d", k, f, exp_f[k]); end
      checks++; if (e !== exp_e[k]) begin errors++; $display("FAIL bound%0d_err: got %b want %b", k, e, exp_e[k]); end
    end
  endtask

  task automatic test_coarse_wrap();
    logic [15:0] seen_c [2];
    logic [4:0]  seen_f [2];
    int n = 0;
    ts_ready = 1'b1;
    wait_cnt(16'hFFFF, 70000);
    hit_valid = 1'b1; thermo_in = 32'h0000_0003;
    @(negedge clk);
    thermo_in = 32'h0000_0007;
    @(negedge clk);
    hit_valid = 1'b0;
    for (int i = 0; i < 8 && n < 2; i++) begin
      @(negedge clk);
      if (ts_valid) begin seen_c[n] = ts_coarse; seen_f[n] = ts_fine; n++; end
      else if (n == 1) break;  // second result must follow on the very next clock
    end
    checks++; if (n != 2) begin errors++; $display("FAIL wrap_count: got %0d results want 2 back-to-back", n); end
    if (n == 2) begin
      checks++; if (seen_c[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_c0: got %0h want ffff", seen_c[0]); end
      checks++; if (seen_c[1] !== 16'h0000) begin errors++; $display("FAIL wrap_c1: got %0h want 0", seen_c[1]); end
      checks++; if (seen_f[0] !== 5'd1 || seen_f[1] !== 5'd2) begin
        errors++; $display("FAIL wrap_fine: got %0d,%0d want 1,2", seen_f[0], seen_f[1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] codes [4];
    codes[0] = 32'h1; codes[1] = 32'h3; codes[2] = 32'h7; codes[3] = 32'hF;
    ts_ready = 1'b0;
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", ts_valid); end
    for (int k = 0; k < 4; k++) begin
      hit_valid = 1'b1; thermo_in = codes[k];
      @(negedge clk);
    end
    hit_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    checks++; if (ts_valid !== 1'b1 || ts_fine !== 5'd0) begin
      errors++; $display("FAIL bp_head: got valid=%b fine=%0d want 1,0", ts_valid, ts_fine);
    end
    @(negedge clk);
    checks++; if (ts_valid !== 1'b1 || ts_fine !== 5'd0 || ts_err !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got valid=%b fine=%0d err=%b want 1,0,0", ts_valid, ts_fine, ts_err);
    end
    ts_ready = 1'b1;
    @(negedge clk);
    checks++; if (ts_valid !== 1'b1 || ts_fine !== 5'd1) begin
      errors++; $display("FAIL bp_drain1: got valid=%b fine=%0d want 1,1", ts_valid, ts_fine);
    end
    @(negedge clk);
    checks++; if (ts_valid !== 1'b1 || ts_fine !== 5'd2) begin
      errors++; $display("FAIL bp_drain2: got valid=%b fine=%0d want 1,2", ts_valid, ts_fine);
    end
    @(negedge clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL bp_dropped: got valid=%b want 0", ts_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clr: got %b want 0", overflow); end
    // Refill and drop again while clearing: the drop must win.
    ts_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hit_valid = 1'b1; thermo_in = codes[k];
      if (k == 3) overflow_clr = 1'b1;
      @(negedge clk);
    end
    hit_valid = 1'b0; overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_set_wins: got %b want 1", overflow); end
    ts_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL bp_redrain: got %b want 0", ts_valid); end
  endtask

  task automatic test_async_reset();
    logic got, e; logic [4:0] f; logic [15:0] c; int lat;
    ts_ready = 1'b0;
    hit_valid = 1'b1; thermo_in = 32'h0000_0003;
    @(negedge clk);
    thermo_in = 32'h0000_001F;
    @(negedge clk);
    hit_valid = 1'b0;
    @(negedge clk);
    checks++; if (ts_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got valid=%b ovf=%b want 1,1", ts_valid, overflow);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", ts_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_ovf: got %b want 0", overflow); end
    checks++; if (ts_coarse !== 16'd0 || ts_fine !== 5'd0) begin
      errors++; $display("FAIL ar_data: got coarse=%0h fine=%0d want 0,0", ts_coarse, ts_fine);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hit_and_wait(32'h0000_003F, got, f, c, e, lat);
    checks++; if (got !== 1'b1 || lat != 3) begin
      errors++; $display("FAIL ar_post_latency: got valid=%b at %0d want 1 at 3", got, lat);
    end
    checks++; if (c !== 16'd0) begin errors++; $display("FAIL ar_coarse_restart: got %0h want 0", c); end
    checks++; if (f !== 5'd5) begin errors++; $display("FAIL ar_fine: got %0d want 5", f); end
    @(negedge clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL ar_no_stale: got %b want 0", ts_valid); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_bubble();
    test_boundaries();
    test_coarse_wrap();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_thermo_decoder.md
Name: tdc_thermo_decoder

Overview:
Downstream stage of the TDC delay-line sampler. Takes a sampled NTAPS-bit thermometer code, applies optional bubble correction, and converts it to a binary fine timestamp. The fine timestamp is paired with a free-running coarse counter value and delivered through a 3-stage elastic pipeline with a valid/ready output handshake.

Parameters:
NTAPS, 32, thermometer width (taps); power of two
FINE_W, 5, fine timestamp width; equals log2(NTAPS)
COARSE_W, 16, coarse counter width

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
hit_valid  input  1  thermo_in holds a captured hit this cycle
thermo_in  input  NTAPS  thermometer code; value k is encoded as bits [k:0]=1
ts_valid  output  1  output timestamp valid
ts_ready  input  1  consumer accepts the timestamp this cycle
ts_fine  output  FINE_W  fine time
ts_coarse  output  COARSE_W  coarse count latched at the hit
ts_err  output  1  code not a valid thermometer after correction, or all-zero
overflow  output  1  sticky: a hit was dropped
overflow_clr  input  1  clears overflow

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset: all pipeline data and valid bits, the coarse counter, ts_valid, ts_fine, ts_coarse, ts_err and overflow go to 0 immediately. Reset mid-operation discards all in-flight hits.
- Coarse counter: increments every clk and wraps from 2^COARSE_W-1 to 0.
- Stage S1 capture: when the hit is accepted, registers thermo_in and the current coarse counter value (the value before that edge's increment).
- Stage S2 correction: c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[NTAPS]=0. The result is registered.
- Stage S3 encode:
  - ones = popcount(c), computed as FINE_W+1 bits.
  - ts_fine = ones-1 when ones>0, else 0.
  - err = (ones==0) OR any i with c[i]==0 and c[i+1]==1.
  - S3 is the output register; its valid bit drives ts_valid.
- Latency: 3 clocks from accepted hit_valid to ts_valid when the pipeline is empty. Throughput is 1 hit per clock with ts_ready held high.
- Elastic advance:
  - S3 empties when ts_valid and ts_ready are both high.
  - Sn moves to Sn+1 when Sn+1 is empty or emptying in the same cycle.
  - A hit is accepted when S1 is empty or advancing. Otherwise it is dropped and overflow is set.
  - ts_ready may be driven combinationally; no combinational path from ts_ready to ts_valid.
- Output stability: while ts_valid is high and ts_ready is low, ts_fine, ts_coarse and ts_err hold stable.
- overflow: set by any drop, cleared by overflow_clr. A drop in the same cycle as overflow_clr leaves overflow set (set wins).
- Boundary codes:
  - All-ones → ts_fine = NTAPS-1, err=0.
  - All-zeros → ts_fine = 0, err=1.
  - Only bit 0 set → ts_fine = 0, err=0.

Optional Feature:
- Macro: TDC_BUBBLE_CORR_EN.
- Defined: S2 applies the majority-of-3 filter described above.
- Undefined: S2 registers the raw code unchanged (c = t). Latency and the handshake stay identical. Bubbles then show up as a reduced popcount and ts_err=1.

Test Plan:
- Single hit, thermo_in=32'h0000_00FF with coarse counter =10, ts_ready=1 → 3 clocks later: ts_valid=1 for one cycle, ts_fine=7, ts_coarse=10, ts_err=0.
- Bubble, thermo_in=32'h0000_00F7 →
  - with TDC_BUBBLE_CORR_EN: ts_fine=7, ts_err=0;
  - without it: ts_fine=6, ts_err=1.
- Boundaries → 32'hFFFF_FFFF gives fine=31, err=0; 32'h0 gives fine=0, err=1; 32'h1 gives fine=0, err=0.
- Backpressure: ts_ready=0, hits on 4 consecutive clocks →
  - first 3 held in S1–S3, 4th dropped, overflow=1;
  - raising ts_ready delivers the 3 results in order on consecutive clocks;
  - overflow_clr pulse → overflow=0;
  - overflow_clr coincident with a drop → overflow stays 1.
- Coarse wrap: hits at counter 16'hFFFF and on the next clock → ts_coarse=16'hFFFF, then 16'h0000.
- Async reset while 2 hits are in flight → ts_valid and overflow drop to 0 without waiting for a clock edge; no stale output after release; coarse counter restarts at 0.
